uart_rx_param: RTL and testbench

- Parametrised UART receiver: the successor to the fixed 8N1 receiver.
- Adds configurable data width, parity, stop-bit count and oversampling, plus 3-sample majority voting and a one-entry output buffer with valid/ready handshake.
- Overrun, parity and framing errors are reported.
- Sits between the pad-side serial input and a byte consumer (FIFO or register interface) in the UART subsystem.

---
 rtl/uart_rx_param.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with majority voting and one-entry output buffer
module uart_rx_param #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD      = 9600,
    parameter int OVS       = 16,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              rx_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              busy,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int DIV   = (CLK_FREQ + BAUD * OVS / 2) / (BAUD * OVS);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            state;
    logic              rx_s1, rx_s2, rx_d;
    logic [DIV_W-1:0]  div_cnt;
    logic [OS_W-1:0]   os_cnt;
    logic [3:0]        bit_cnt;
    logic              stop_cnt;
    logic [DATA_W-1:0] shift;
    logic              samp_a, samp_b;
    logic              par_bad, frame_bad;

    logic tick, start_det, vote_now, bit_end, vote, par_exp, finish;

    assign tick      = (div_cnt == DIV_W'(DIV - 1));
    assign start_det = (state == S_IDLE) && rx_en && rx_d && !rx_s2;
    assign vote_now  = tick && (os_cnt == OS_W'(OVS / 2 + 1));
    assign bit_end   = tick && (os_cnt == OS_W'(OVS - 1));
    assign vote      = (samp_a & samp_b) | (samp_a & rx_s2) | (samp_b & rx_s2);
    assign par_exp   = (PARITY == 2) ? ~(^shift) : ^shift;
    assign finish    = rx_en && (state == S_STOP) && vote_now &&
                       (stop_cnt == 1'(STOP_BITS - 1));

    // rx_d holds the previous synchronised level for start-edge detection
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            div_cnt <= '0;
        else if (start_det || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            par_bad    <= 1'b0;
            frame_bad  <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (tick) begin
                os_cnt <= (os_cnt == OS_W'(OVS - 1)) ? '0 : os_cnt + 1'b1;
                if (os_cnt == OS_W'(OVS / 2 - 1))
                    samp_a <= rx_s2;
                if (os_cnt == OS_W'(OVS / 2))
                    samp_b <= rx_s2;
            end

            // Output buffer: a finishing frame may load in the same cycle the old word is accepted
            if (finish) begin
                if (!valid || ready) begin
                    data       <= shift;
                    parity_err <= par_bad;
                    frame_err  <= frame_bad | ~vote;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (!rx_en) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_det) begin
                            state     <= S_START;
                            busy      <= 1'b1;
                            os_cnt    <= '0;
                            bit_cnt   <= '0;
                            stop_cnt  <= 1'b0;
                            par_bad   <= 1'b0;
                            frame_bad <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (vote_now && vote) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else if (bit_end) begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (vote_now)
                            shift <= {vote, shift[DATA_W-1:1]};
                        if (bit_end) begin
                            if (bit_cnt == 4'(DATA_W - 1))
                                state <= (PARITY != 0) ? S_PARITY : S_STOP;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (vote_now)
                            par_bad <= (vote != par_exp);
                        if (bit_end)
                            state <= S_STOP;
                    end
                    S_STOP: begin
                        if (vote_now) begin
                            if (!vote)
                                frame_bad <= 1'b1;
                            if (stop_cnt == 1'(STOP_BITS - 1)) begin
                                state <= (frame_bad || !vote) ? S_BREAK : S_IDLE;
                                busy  <= frame_bad || !vote;
                            end
                        end
                        if (bit_end)
                            stop_cnt <= stop_cnt + 1'b1;
                    end
                    S_BREAK: begin
                        if (rx_s2) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (8N1 instance and 7E2 instance, 32 clocks per bit)
module tb_uart_rx_param;

    localparam int BIT = 32;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic rx_en = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1;
    logic ready0 = 1'b1, ready1 = 1'b1;

    logic [7:0] data0;
    logic       valid0, busy0, pe0, fe0, ovr0;
    logic [6:0] data1;
    logic       valid1, busy1, pe1, fe1, ovr1;

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0;
    int acc0 = 0, vhi0 = 0, ovr_cnt0 = 0, rise0 = 0, ovr_at0 = 0;
    logic [7:0] last0 = '0;
    logic       lpe0 = 1'b0, lfe0 = 1'b0, valid0_q = 1'b0;
    logic [6:0] last1 = '0;
    logic       lpe1 = 1'b0, lfe1 = 1'b0;

    uart_rx_param #(
        .CLK_FREQ(3200000), .BAUD(100000), .OVS(16),
        .DATA_W(8), .PARITY(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .arst_n(arst_n), .rx_en(rx_en), .rx(rx0),
        .data(data0), .valid(valid0), .ready(ready0), .busy(busy0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ovr0)
    );

    uart_rx_param #(
        .CLK_FREQ(3200000), .BAUD(100000), .OVS(16),
        .DATA_W(7), .PARITY(1), .STOP_BITS(2)
    ) dut1 (
        .clk(clk), .arst_n(arst_n), .rx_en(rx_en), .rx(rx1),
        .data(data1), .valid(valid1), .ready(ready1), .busy(busy1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ovr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid0 && ready0) begin
            acc0  <= acc0 + 1;
            last0 <= data0;
            lpe0  <= pe0;
            lfe0  <= fe0;
        end
        if (valid0)
            vhi0 <= vhi0 + 1;
        if (valid0 && !valid0_q)
            rise0 <= cyc;
        if (ovr0) begin
            ovr_cnt0 <= ovr_cnt0 + 1;
            ovr_at0  <= cyc;
        end
        valid0_q <= valid0;
        if (valid1 && ready1) begin
            last1 <= data1;
            lpe1  <= pe1;
            lfe1  <= fe1;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic send(input int sel, input logic [15:0] bits, input int n, input int gbit);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            if (i == 0) start_cyc = cyc;
            if (i == gbit) begin
                repeat (16) @(negedge clk);
                drive(sel, ~bits[i]);
                @(negedge clk);
                drive(sel, bits[i]);
                repeat (BIT - 17) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
    endtask

    function automatic logic [15:0] f0(input logic [7:0] d, input logic stp);
        return {6'b0, stp, d, 1'b0};
    endfunction

    function automatic logic [15:0] f1(input logic [6:0] d, input logic p, input logic s2);
        return {5'b0, s2, 1'b1, p, d, 1'b0};
    endfunction

    logic [7:0] pat [8] = '{8'h55, 8'hAA, 8'hFF, 8'h00, 8'hF0, 8'h0F, 8'hB4, 8'h6D};
    int base, vbase, obase;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data",  32'(data0), 32'h0);
        chk("rst_valid", 32'(valid0), 32'h0);
        chk("rst_busy",  32'(busy0), 32'h0);
        chk("rst_flags", 32'({pe0, fe0, ovr0}), 32'h0);
        chk("rst_valid1", 32'(valid1), 32'h0);
        arst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Back-to-back 8N1 frames, ready held high
        vbase = vhi0;
        for (int i = 0; i < 8; i++) begin
            base = acc0;
            send(0, f0(pat[i], 1'b1), 10, -1);
            chk($sformatf("t1_data[%0d]", i), 32'(last0), 32'(pat[i]));
            chk($sformatf("t1_count[%0d]", i), 32'(acc0 - base), 32'd1);
            chk($sformatf("t1_flags[%0d]", i), 32'({lpe0, lfe0}), 32'h0);
            if (i == 0)
                chk("t1_latency", 32'(rise0 - start_cyc), 32'd311);
        end
        chk("t1_valid_cycles", 32'(vhi0 - vbase), 32'd8);

        // Stop bit low, line held low afterwards
        send(0, f0(8'h55, 1'b0), 10, -1);
        repeat (64) @(negedge clk);
        chk("t2_data", 32'(last0), 32'h55);
        chk("t2_fe", 32'(lfe0), 32'h1);
        chk("t2_busy_break", 32'(busy0), 32'h1);
        rx0 = 1'b1;
        repeat (8) @(negedge clk);
        chk("t2_busy_idle", 32'(busy0), 32'h0);
        send(0, f0(8'hA5, 1'b1), 10, -1);
        chk("t2_data2", 32'(last0), 32'hA5);
        chk("t2_fe2", 32'(lfe0), 32'h0);

        // 7E2 instance
        send(1, f1(7'h41, 1'b0, 1'b1), 11, -1);
        chk("t3_data_a", 32'(last1), 32'h41);
        chk("t3_pe_a", 32'({lpe1, lfe1}), 32'h0);
        send(1, f1(7'h41, 1'b1, 1'b1), 11, -1);
        chk("t3_data_b", 32'(last1), 32'h41);
        chk("t3_pe_b", 32'({lpe1, lfe1}), 32'h2);
        send(1, f1(7'h13, 1'b1, 1'b1), 11, -1);
        chk("t3_data_c", 32'(last1), 32'h13);
        chk("t3_pe_c", 32'({lpe1, lfe1}), 32'h0);
        send(1, f1(7'h2A, 1'b1, 1'b0), 11, -1);
        repeat (32) @(negedge clk);
        chk("t3_fe_stop2", 32'({lpe1, lfe1}), 32'h1);
        chk("t3_busy_break", 32'(busy1), 32'h1);
        rx1 = 1'b1;
        repeat (8) @(negedge clk);
        chk("t3_busy_idle", 32'(busy1), 32'h0);

        // Overrun with consumer stalled
        ready0 = 1'b0;
        base  = acc0;
        obase = ovr_cnt0;
        send(0, f0(8'h12, 1'b1), 10, -1);
        chk("t4_valid", 32'(valid0), 32'h1);
        chk("t4_data", 32'(data0), 32'h12);
        send(0, f0(8'h34, 1'b1), 10, -1);
        chk("t4_ovr_count", 32'(ovr_cnt0 - obase), 32'd1);
        chk("t4_ovr_latency", 32'(ovr_at0 - start_cyc), 32'd311);
        chk("t4_hold_data", 32'(data0), 32'h12);
        chk("t4_hold_valid", 32'(valid0), 32'h1);
        ready0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("t4_valid_drop", 32'(valid0), 32'h0);
        chk("t4_accepted", 32'(last0), 32'h12);
        chk("t4_accept_count", 32'(acc0 - base), 32'd1);

        // Short low glitch is a false start
        base  = acc0;
        vbase = vhi0;
        rx0 = 1'b0;
        repeat (8) @(negedge clk);
        chk("t5_busy_start", 32'(busy0), 32'h1);
        repeat (2) @(negedge clk);
        rx0 = 1'b1;
        repeat (64) @(negedge clk);
        chk("t5_false_busy", 32'(busy0), 32'h0);
        chk("t5_false_valid", 32'(vhi0 - vbase), 32'd0);
        send(0, f0(8'h3C, 1'b1), 10, 3);
        chk("t5_vote_data", 32'(last0), 32'h3C);
        chk("t5_vote_count", 32'(acc0 - base), 32'd1);

        // Reset pulse mid-frame
        base = acc0;
        rx0 = 1'b0;
        repeat (BIT) @(negedge clk);
        rx0 = 1'b1;
        repeat (16) @(negedge clk);
        arst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy0), 32'h0);
        chk("t6_rst_data", 32'(data0), 32'h0);
        @(negedge clk);
        arst_n = 1'b1;
        repeat (64) @(negedge clk);
        chk("t6_rst_novalid", 32'(acc0 - base), 32'd0);

        // rx_en dropped mid-frame
        rx0 = 1'b0;
        repeat (BIT) @(negedge clk);
        rx0 = 1'b1;
        repeat (16) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        rx_en = 1'b1;
        chk("t6_en_busy", 32'(busy0), 32'h0);
        repeat (64) @(negedge clk);
        chk("t6_en_novalid", 32'(acc0 - base), 32'd0);
        send(0, f0(8'hC3, 1'b1), 10, -1);
        chk("t6_data", 32'(last0), 32'hC3);
        chk("t6_flags", 32'({lpe0, lfe0}), 32'h0);
        chk("t6_count", 32'(acc0 - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
